// File: rtl/sram_ctrl_multibeat_pkg.sv
// Shared types and elaboration helpers for the multi-beat SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    function automatic int unsigned beats(int unsigned data_w, int unsigned sram_dw);
        return data_w / sram_dw;
    endfunction

    function automatic int unsigned clog2(int unsigned v);
        int unsigned r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Full 32-bit SRAM word address; callers truncate to the bus width.
    function automatic logic [31:0] word_addr(logic [31:0] addr, logic [31:0] base,
                                              int unsigned shift, int unsigned nbeats,
                                              logic [31:0] beat);
        return ((addr - base) >> shift) * nbeats + beat;
    endfunction

endpackage

// File: rtl/sram_ctrl_multibeat.sv
// MEM-stage SRAM controller: splits each CPU word into sequential SRAM beats
// with a programmable number of wait cycles per beat.
module sram_ctrl_multibeat
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SRAM_DW     = 16,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_en,
    input  logic               write_en,
    input  logic [31:0]        address,
    input  logic [DATA_W-1:0]  write_data,
    output logic [DATA_W-1:0]  read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned BEATS = beats(DATA_W, SRAM_DW);
    localparam int unsigned SHIFT = clog2(DATA_W / 8);
    localparam int unsigned BW    = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam int unsigned WW    = (WAIT_CYCLES > 0) ? clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_CYCLES);

    state_t            state;
    logic [BW-1:0]     beat;
    logic [WW-1:0]     wait_cnt;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              beat_end;
    logic              active;

    assign beat_end = (wait_cnt == LAST_WAIT);
    assign active   = (state == READ) || (state == WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            wait_cnt  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_en || write_en) begin
                        addr_q   <= address;
                        wdata_q  <= write_data;
                        beat     <= '0;
                        wait_cnt <= '0;
                        state    <= read_en ? READ : WRITE;
                    end
                end
                READ, WRITE: begin
                    // Sample on the edge that closes the beat, after the full access time.
                    if (state == READ && beat_end)
                        read_data[beat*SRAM_DW +: SRAM_DW] <= sram_dq;
                    if (beat_end) begin
                        wait_cnt <= '0;
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM pins decode only from registered state so they never glitch on input changes.
    assign sram_addr = active ? SRAM_AW'(word_addr(addr_q, 32'(BASE_ADDR), SHIFT, BEATS, 32'(beat)))
                              : '0;
    assign sram_ce_n = !active;
    assign sram_oe_n = (state != READ);
    assign sram_we_n = !((state == WRITE) && (!beat_end || WAIT_CYCLES == 0));
    assign sram_ub_n = !active;
    assign sram_lb_n = !active;
    assign sram_dq   = (state == WRITE) ? wdata_q[beat*SRAM_DW +: SRAM_DW] : 'z;

    assign ready = (state == DONE) || (state == IDLE && !read_en && !write_en);

endmodule

// File: tb/tb_sram_ctrl_multibeat.sv
// Self-checking bench for sram_ctrl_multibeat with an asynchronous SRAM model.
module tb_sram_ctrl_multibeat;

    logic        clk = 0;
    logic        rst = 1;
    logic        read_en = 0, write_en = 0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    logic        rd2 = 0, wr2 = 0;
    logic [31:0] addr2 = '0, wdata2 = '0;
    logic [31:0] rdata2;
    logic        rdy2;
    wire  [31:0] dq2;
    logic [17:0] sram_addr2;
    logic        we2_n, oe2_n, ce2_n, ub2_n, lb2_n;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    sram_ctrl_multibeat dut (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_dq(sram_dq), .sram_addr(sram_addr),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    sram_ctrl_multibeat #(
        .DATA_W(32), .SRAM_DW(32), .SRAM_AW(18), .BASE_ADDR(1024), .WAIT_CYCLES(0)
    ) dut2 (
        .clk(clk), .rst(rst), .read_en(rd2), .write_en(wr2),
        .address(addr2), .write_data(wdata2), .read_data(rdata2),
        .ready(rdy2), .sram_dq(dq2), .sram_addr(sram_addr2),
        .sram_we_n(we2_n), .sram_oe_n(oe2_n), .sram_ce_n(ce2_n),
        .sram_ub_n(ub2_n), .sram_lb_n(lb2_n)
    );

    // Undriven bus reads as all ones, so "released" is visible as 16'hFFFF.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (sram_dq[i]);
    end

    logic [15:0] mem [0:262143];
    logic [31:0] mem2 [0:15];
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 'z;
    assign dq2     = (!ce2_n && !oe2_n && we2_n) ? mem2[sram_addr2[3:0]] : 'z;
    always @(negedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr] = sram_dq;
    always @(negedge clk) if (!ce2_n && !we2_n) mem2[sram_addr2[3:0]] = dq2;

    int          stall;
    logic [31:0] rdata;
    bit          timeout;
    logic [17:0] addr_log[$];
    int          we_low_cycles;
    bit          dq_drv;
    bit          lane_bad;

    // Drives one request from IDLE and observes it until DONE; leaves time at DONE's negedge.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input bit hold);
        read_en = rd; write_en = wr; address = a; write_data = wd;
        stall = 0; timeout = 1; addr_log.delete(); we_low_cycles = 0;
        dq_drv = 0; lane_bad = 0; rdata = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!sram_ce_n && (addr_log.size() == 0 || addr_log[$] !== sram_addr))
                addr_log.push_back(sram_addr);
            if (!sram_we_n) we_low_cycles++;
            if (sram_oe_n && sram_dq !== 16'hFFFF) dq_drv = 1;
            if (!sram_ce_n && (sram_ub_n || sram_lb_n)) lane_bad = 1;
            if (!ready) stall++;
            else if (stall > 0) begin
                rdata = read_data; timeout = 0; break;
            end
            @(posedge clk); #1;
            if (!hold) begin read_en = 0; write_en = 0; end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
            errors++; $display("FAIL reset_strobes got %b exp 11111",
                               {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
        end
        checks++;
        if (sram_addr !== 18'd0 || sram_dq !== 16'hFFFF) begin
            errors++; $display("FAIL reset_bus got addr %h dq %h exp 0 / released", sram_addr, sram_dq);
        end
        checks++;
        if (read_data !== 32'd0 || ready !== 1'b1) begin
            errors++; $display("FAIL reset_rdata got %h ready %b exp 0 / 1", read_data, ready);
        end
        @(posedge clk); #1; rst = 0;
    endtask

    task automatic test_read();
        logic [31:0] exp;
        exp_q.push_back(32'hABCD1234);
        run_access(1, 0, 32'd1024, 32'd0, 0);
        checks++;
        if (timeout) begin errors++; $display("FAIL read_timeout no DONE within bound"); end
        checks++;
        if (stall != 13) begin errors++; $display("FAIL read_stall got %0d exp 13", stall); end
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 18'd0 || addr_log[1] !== 18'd1) begin
            errors++; $display("FAIL read_addr got n=%0d first %h exp 0,1", addr_log.size(),
                               addr_log.size() > 0 ? addr_log[0] : 18'h0);
        end
        exp = exp_q.pop_front();
        checks++;
        if (rdata !== exp) begin errors++; $display("FAIL read_data got %h exp %h", rdata, exp); end
        checks++;
        if (we_low_cycles != 0 || lane_bad) begin
            errors++; $display("FAIL read_we got we_low %0d lane_bad %0d exp 0 0", we_low_cycles, lane_bad);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        run_access(0, 1, 32'd1032, 32'hDEADBEEF, 0);
        checks++;
        if (timeout || stall != 13) begin
            errors++; $display("FAIL write_stall got %0d timeout %0d exp 13", stall, timeout);
        end
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 18'd4 || addr_log[1] !== 18'd5) begin
            errors++; $display("FAIL write_addr got n=%0d exp 4,5", addr_log.size());
        end
        checks++;
        if (mem[4] !== 16'hBEEF || mem[5] !== 16'hDEAD) begin
            errors++; $display("FAIL write_mem got %h %h exp beef dead", mem[4], mem[5]);
        end
        checks++;
        if (we_low_cycles != 10 || !dq_drv) begin
            errors++; $display("FAIL write_we got we_low %0d drv %0d exp 10 1", we_low_cycles, dq_drv);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (sram_dq !== 16'hFFFF || ready !== 1'b1) begin
            errors++; $display("FAIL write_release got dq %h ready %b exp released 1", sram_dq, ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_both_requests();
        logic [31:0] exp;
        exp_q.push_back(32'hABCD1234);
        run_access(1, 1, 32'd1024, 32'h0BADF00D, 0);
        exp = exp_q.pop_front();
        checks++;
        if (timeout || rdata !== exp) begin
            errors++; $display("FAIL both_data got %h exp %h", rdata, exp);
        end
        checks++;
        if (we_low_cycles != 0 || dq_drv || mem[0] !== 16'h1234) begin
            errors++; $display("FAIL both_nowrite got we_low %0d drv %0d mem0 %h exp 0 0 1234",
                               we_low_cycles, dq_drv, mem[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        bit saw_active = 0;
        read_en = 0; write_en = 1; address = 32'd1032; write_data = 32'h11112222;
        @(posedge clk); #1; write_en = 0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (sram_addr !== 18'd4 || sram_we_n !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre got addr %h we_n %b exp 4 0", sram_addr, sram_we_n);
        end
        rst = 1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        checks++;
        if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1 || sram_dq !== 16'hFFFF || ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_idle got we_n %b ce_n %b dq %h ready %b exp 1 1 released 1",
                               sram_we_n, sram_ce_n, sram_dq, ready);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!sram_ce_n) saw_active = 1;
        end
        checks++;
        if (saw_active || mem[5] !== 16'hDEAD) begin
            errors++; $display("FAIL rstmid_nobeat1 got active %0d mem5 %h exp 0 dead", saw_active, mem[5]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        int          st = 0;
        bit          done = 0;
        logic [17:0] a_seen = '1;
        logic [31:0] got = '0;
        logic [31:0] exp;
        exp_q.push_back(32'hCAFEF00D);
        rd2 = 1; addr2 = 32'd1028;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!ce2_n) a_seen = sram_addr2;
            if (!rdy2) st++;
            else if (st > 0) begin got = rdata2; done = 1; break; end
            @(posedge clk); #1; rd2 = 0;
        end
        exp = exp_q.pop_front();
        checks++;
        if (!done || st != 2) begin errors++; $display("FAIL single_stall got %0d done %0d exp 2", st, done); end
        checks++;
        if (a_seen !== 18'd1) begin errors++; $display("FAIL single_addr got %h exp 1", a_seen); end
        checks++;
        if (got !== exp) begin errors++; $display("FAIL single_data got %h exp %h", got, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        exp_q.push_back(32'hAAAA5555);
        exp_q.push_back(32'hAAAA5555);
        run_access(1, 0, 32'd1020, 32'd0, 1);
        exp = exp_q.pop_front();
        checks++;
        if (timeout || stall != 13 || rdata !== exp) begin
            errors++; $display("FAIL b2b_first got %h stall %0d exp %h 13", rdata, stall, exp);
        end
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 18'h3FFFE || addr_log[1] !== 18'h3FFFF) begin
            errors++; $display("FAIL b2b_wrap got n=%0d first %h exp 3fffe,3ffff", addr_log.size(),
                               addr_log.size() > 0 ? addr_log[0] : 18'h0);
        end
        @(posedge clk); #1;
        run_access(1, 0, 32'd1020, 32'd0, 0);
        exp = exp_q.pop_front();
        checks++;
        if (timeout || stall != 13 || rdata !== exp) begin
            errors++; $display("FAIL b2b_second got %h stall %0d exp %h 13", rdata, stall, exp);
        end
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 18'h3FFFE || addr_log[1] !== 18'h3FFFF) begin
            errors++; $display("FAIL b2b_wrap2 got n=%0d exp 3fffe,3ffff", addr_log.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        mem[4] = 16'h0000;
        mem[5] = 16'h0000;
        mem[18'h3FFFE] = 16'h5555;
        mem[18'h3FFFF] = 16'hAAAA;
        mem2[1] = 32'hCAFEF00D;
        test_reset();
        test_read();
        test_write();
        test_both_requests();
        test_reset_mid_write();
        test_single_beat();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl_multibeat.md
Name: sram_ctrl_multibeat

Overview:
Parametrised SRAM controller between the MEM stage and an external asynchronous SRAM with a data bus narrower than or equal to the CPU word. Each CPU load/store is split into BEATS = DATA_W/SRAM_DW sequential SRAM beats, each lasting a programmable number of wait cycles. `ready` stalls the pipeline until the word completes. Adds to the existing controller: multi-beat access, parametric timing, a registered read word, and explicit chip, output and byte-lane strobes.

Parameters:
DATA_W, 32, CPU word width (multiple of SRAM_DW).
SRAM_DW, 16, SRAM data bus width.
SRAM_AW, 18, SRAM address width.
BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0.
WAIT_CYCLES, 5, extra cycles per beat (beat length = WAIT_CYCLES+1).

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
read_en  in  1  load request.
write_en  in  1  store request.
address  in  32  CPU byte address.
write_data  in  DATA_W  store data.
read_data  out  DATA_W  registered load data, valid when ready=1 in DONE.
ready  out  1  low = stall pipeline.
sram_dq  inout  SRAM_DW  SRAM data bus.
sram_addr  out  SRAM_AW  SRAM word address.
sram_we_n  out  1  write enable, active-low.
sram_oe_n  out  1  output enable, active-low.
sram_ce_n  out  1  chip enable, active-low.
sram_ub_n, sram_lb_n  out  1 each  byte lanes: 0 while ce_n=0, else 1.

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous and active-high. At the edge where rst=1: state=IDLE, counters=0, read_data=0, latched address/data=0.
- Outputs at reset: ce_n=oe_n=we_n=1, ub_n=lb_n=1, sram_dq=Z, sram_addr=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE: read_en → READ; else write_en → WRITE. Read wins if both are high. The accepting edge latches address and write_data.
- READ/WRITE: beat counter b in 0..BEATS-1 and wait counter w in 0..WAIT_CYCLES. When w reaches WAIT_CYCLES: w←0, b←b+1. At the last beat's final cycle → DONE.
- DONE: lasts 1 cycle, then → IDLE unconditionally.
- ready is combinational: 1 in DONE, or in IDLE with read_en=write_en=0; 0 otherwise.
- Stall length: ready is low for 1 + BEATS*(WAIT_CYCLES+1) cycles (13 at defaults).
- Input changes while busy are ignored. A request still held during DONE starts a new access on the following IDLE cycle.
- Address: sram_addr = truncate_SRAM_AW(((latched_addr − BASE_ADDR) >> log2(DATA_W/8)) * BEATS + b). Subtraction is 32-bit unsigned, so addresses below BASE_ADDR wrap.
- Beat ordering: beat 0 = least-significant slice.
- Read timing: ce_n=oe_n=0 for the whole access. read_data[b*SRAM_DW +: SRAM_DW] captures sram_dq on the edge ending beat b's last cycle.
- Write timing: ce_n=0; sram_dq drives write_data slice b for every cycle of beat b. we_n=0 for w<WAIT_CYCLES and we_n=1 on the beat's last cycle (data hold). If WAIT_CYCLES=0, we_n is low for that single cycle.
- Glitch rule: all SRAM pins decode from registered state/counters/latches only, never from inputs.
- Tri-state: sram_dq is Z whenever state≠WRITE.
- Reset mid-access: next edge returns to IDLE, the pins return to their reset values, and the remaining beats are not issued.

Decomposition:
- Package sram_ctrl_pkg holds: state enum (IDLE/READ/WRITE/DONE), function beats(DATA_W, SRAM_DW), and a clog2 helper for the byte-offset shift.
- The block is a single module; the beat and wait counters are too small to justify a sub-module.

Test Plan:
1. Defaults; SRAM model word0=0x1234, word1=0xABCD; read at 1024 → sram_addr 0 then 1, ready low 13 cycles, read_data=0xABCD1234 in DONE, we_n never 0.
2. Write 0xDEADBEEF at 1032 → addr 4 gets 0xBEEF, addr 5 gets 0xDEAD; we_n low 5 cycles per beat; dq Z after DONE.
3. read_en=write_en=1 at 1024 → read performed, we_n stays 1, dq stays Z.
4. rst pulsed during cycle 4 of a write's beat 0 → next cycle IDLE, we_n=1, dq=Z; beat 1 address never driven.
5. SRAM_DW=32, WAIT_CYCLES=0 → single beat; ready low exactly 2 cycles; read 0xCAFEF00D at 1028 returns 0xCAFEF00D from sram_addr 1.
6. read_en held across DONE with address 1020 → second access starts right after IDLE, sram_addr=0x3FFFE then 0x3FFFF (wrap).
